// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding and request classification helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STORE  = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4,
      ST_RESP   = 3'd5
   } lsu_state_t;

   // Unsigned widths exist only for loads; stores accept B/H/W only.
   function automatic logic f3_legal(input logic load, input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = load;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // funct3[1:0] carries the access size for every legal code.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = lo[0];
         2'b10:   mis = |lo;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Clears the address bits below the access granularity. A no-op for
   // aligned requests, so it is safe to apply regardless of trap mode.
   function automatic logic [31:0] f3_force_addr(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] a;
      a = addr;
      case (f3[1:0])
         2'b01:   a[0]   = 1'b0;
         2'b10:   a[1:0] = 2'b00;
         default: a      = addr;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/halfword extraction with sign/zero
// extension, and store lane merge into an existing memory word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_word
);

   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lo)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lo[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_BU:   r = {24'd0, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_HU:   r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  lo,
                                               input logic [2:0]  f3);
      logic [31:0] r;
      r = word;
      case (f3)
         F3_B: begin
            case (lo)
               2'd0:    r[7:0]   = wdata[7:0];
               2'd1:    r[15:8]  = wdata[7:0];
               2'd2:    r[23:16] = wdata[7:0];
               default: r[31:24] = wdata[7:0];
            endcase
         end
         F3_H: begin
            if (lo[1]) r[31:16] = wdata[15:0];
            else       r[15:0]  = wdata[15:0];
         end
         default: r = wdata;
      endcase
      return r;
   endfunction

   // Both results are pure functions of the current word and request fields.
   always_comb begin
      o_load_data  = load_extract(i_word, i_addr_lo, i_funct3);
      o_store_word = store_merge(i_word, i_wdata, i_addr_lo, i_funct3);
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and a word-only, combinational-read data
// memory. Sub-word stores are performed as read-modify-write.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a request
// LOAD      | memory read of the load word, lane extracted at the edge
// STORE     | full-word write of store data
// RMW_RD    | read old word, merge new byte/halfword lane
// RMW_WR    | write merged word
// RESP      | response issued (visible the following cycle), back to IDLE
module lsu
   import lsu_pkg::*;
#(
   parameter logic MISALIGN_TRAP = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_load,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic        o_busy,
   output logic        o_mem_read,
   output logic        o_mem_write,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   lsu_state_t  r_state;
   logic [31:0] r_addr;
   logic [2:0]  r_funct3;
   logic        r_load;
   logic [31:0] r_wdata;
   logic        r_err;
   logic [31:0] r_ld_data;
   logic        r_busy;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;
   logic        r_mem_read;
   logic        r_mem_write;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;

   logic        w_accept;
   logic        w_req_err;
   logic [31:0] w_eff_addr;
   logic [31:0] w_word_addr;
   logic [31:0] w_ld_data;
   logic [31:0] w_st_word;

   assign o_req_ready = (r_state == ST_IDLE) & ~i_rst;
   assign w_accept    = i_req_valid & o_req_ready;

   assign w_req_err   = ~f3_legal(i_req_load, i_req_funct3)
                      | (MISALIGN_TRAP & f3_misaligned(i_req_funct3, i_req_addr[1:0]));
   assign w_eff_addr  = f3_force_addr(i_req_funct3, i_req_addr);
   assign w_word_addr = {w_eff_addr[31:2], 2'b00};

   lsu_align u_align (
      .i_word       (i_mem_rdata),
      .i_wdata      (r_wdata),
      .i_addr_lo    (r_addr[1:0]),
      .i_funct3     (r_funct3),
      .o_load_data  (w_ld_data),
      .o_store_word (w_st_word)
   );

   // Sequencer with registered memory and response outputs; every output
   // defaults to 0 each cycle and is raised only by the state that owns it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_funct3     <= '0;
         r_load       <= 1'b0;
         r_wdata      <= '0;
         r_err        <= 1'b0;
         r_ld_data    <= '0;
         r_busy       <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr    <= w_eff_addr;
                  r_funct3  <= i_req_funct3;
                  r_load    <= i_req_load;
                  r_wdata   <= i_req_wdata;
                  r_err     <= w_req_err;
                  r_ld_data <= '0;
                  r_busy    <= 1'b1;
                  if (w_req_err) begin
                     r_state <= ST_RESP;
                  end else if (i_req_load) begin
                     r_state    <= ST_LOAD;
                     r_mem_read <= 1'b1;
                     r_mem_addr <= w_word_addr;
                  end else if (i_req_funct3 == F3_W) begin
                     r_state     <= ST_STORE;
                     r_mem_write <= 1'b1;
                     r_mem_addr  <= w_word_addr;
                     r_mem_wdata <= i_req_wdata;
                  end else begin
                     r_state    <= ST_RMW_RD;
                     r_mem_read <= 1'b1;
                     r_mem_addr <= w_word_addr;
                  end
               end
            end
            ST_LOAD: begin
               r_ld_data <= w_ld_data;
               r_state   <= ST_RESP;
            end
            ST_STORE: begin
               r_state <= ST_RESP;
            end
            ST_RMW_RD: begin
               r_mem_write <= 1'b1;
               r_mem_addr  <= r_mem_addr;
               r_mem_wdata <= w_st_word;
               r_state     <= ST_RMW_WR;
            end
            ST_RMW_WR: begin
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               r_resp_valid <= 1'b1;
               r_resp_err   <= r_err;
               r_resp_rdata <= (r_load & ~r_err) ? r_ld_data : 32'd0;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Enables are gated by reset so an aborted access never reaches memory.
   assign o_mem_read   = r_mem_read & ~i_rst;
   assign o_mem_write  = r_mem_write & ~i_rst;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_busy       = r_busy;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: transaction-level reference model predicting every output
// cycle by cycle, directed literal scenarios plus randomized traffic.
module tb_lsu;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_req_valid;
   logic        i_req_load;
   logic [2:0]  i_req_funct3;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic [31:0] w_mem_rdata;
   logic        o_req_ready;
   logic        o_resp_valid;
   logic [31:0] o_resp_rdata;
   logic        o_resp_err;
   logic        o_busy;
   logic        o_mem_read;
   logic        o_mem_write;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;

   always #5 clk = ~clk;

   lsu #(.MISALIGN_TRAP(1'b1)) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_load   (i_req_load),
      .i_req_funct3 (i_req_funct3),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .o_resp_valid (o_resp_valid),
      .o_resp_rdata (o_resp_rdata),
      .o_resp_err   (o_resp_err),
      .o_busy       (o_busy),
      .o_mem_read   (o_mem_read),
      .o_mem_write  (o_mem_write),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rdata  (w_mem_rdata)
   );

   // data memory seen by the DUT (64 words, addresses 0..0xFF)
   logic [31:0] bmem [64] = '{default: 32'h0};
   assign w_mem_rdata = bmem[o_mem_addr[7:2]];
   always @(posedge clk) if (o_mem_write) bmem[o_mem_addr[7:2]] <= o_mem_wdata;

   int n_cmp = 0;
   int n_bad = 0;
   int resp_cnt = 0;

   // reference model: memory image and a ring of expected per-cycle outputs
   logic [31:0] mmem [64] = '{default: 32'h0};
   bit          e_busy [16];
   bit          e_mr   [16];
   bit          e_mw   [16];
   bit          e_rv   [16];
   bit          e_err  [16];
   bit          e_cm   [16];
   bit   [31:0] e_addr [16];
   bit   [31:0] e_wd   [16];
   bit   [31:0] e_rd   [16];
   bit   [31:0] e_cw   [16];
   bit   [5:0]  e_ci   [16];
   int          cur = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_legal(input bit ld, input logic [2:0] f3);
      if (ld) return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      return f3 inside {3'b000, 3'b001, 3'b010};
   endfunction

   function automatic int m_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input int lo);
      logic [31:0] v;
      int sz;
      sz = m_size(f3);
      if (sz == 4) return w;
      v = w >> (8 * lo);
      if (sz == 1) begin
         v = v & 32'hFF;
         if (!f3[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else begin
         v = v & 32'hFFFF;
         if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] wd,
                                           input logic [2:0] f3, input int lo);
      logic [31:0] mask;
      mask = ((m_size(f3) == 1) ? 32'hFF : 32'hFFFF) << (8 * lo);
      return (w & ~mask) | ((wd << (8 * lo)) & mask);
   endfunction

   // Request accepted at the next edge: fill the expected cycles after it.
   task automatic m_accept(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
      int lat, lo, s0, s1, sr;
      bit err;
      logic [5:0]  idx;
      logic [31:0] wa;
      lo  = int'(a[1:0]);
      idx = a[7:2];
      wa  = {a[31:2], 2'b00};
      err = !m_legal(ld, f3) || ((lo % m_size(f3)) != 0);
      s0  = (cur + 1) % 16;
      s1  = (cur + 2) % 16;
      if (err) lat = 1;
      else if (ld || m_size(f3) == 4) lat = 2;
      else lat = 3;
      sr = (cur + 1 + lat) % 16;
      for (int j = 0; j < lat; j++) e_busy[(cur + 1 + j) % 16] = 1'b1;
      e_rv[sr]  = 1'b1;
      e_err[sr] = err;
      e_rd[sr]  = 32'h0;
      if (!err) begin
         if (ld) begin
            e_mr[s0]   = 1'b1;
            e_addr[s0] = wa;
            e_rd[sr]   = m_load(mmem[idx], f3, lo);
         end else if (m_size(f3) == 4) begin
            e_mw[s0]   = 1'b1;
            e_addr[s0] = wa;
            e_wd[s0]   = wd;
            e_cm[s0]   = 1'b1;
            e_ci[s0]   = idx;
            e_cw[s0]   = wd;
         end else begin
            e_mr[s0]   = 1'b1;
            e_addr[s0] = wa;
            e_mw[s1]   = 1'b1;
            e_addr[s1] = wa;
            e_wd[s1]   = m_merge(mmem[idx], wd, f3, lo);
            e_cm[s1]   = 1'b1;
            e_ci[s1]   = idx;
            e_cw[s1]   = e_wd[s1];
         end
      end
   endtask

   task automatic m_clear(input int s);
      e_busy[s] = 0; e_mr[s] = 0; e_mw[s] = 0; e_rv[s] = 0; e_err[s] = 0; e_cm[s] = 0;
      e_addr[s] = 0; e_wd[s] = 0; e_rd[s] = 0; e_cw[s] = 0; e_ci[s] = 0;
   endtask

   // per-cycle compare against the model, sampled on the falling edge
   initial begin
      bit exp_ready;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_ready = !i_rst && !e_busy[cur];
         chk1 ("req_ready",  o_req_ready,  exp_ready);
         chk1 ("busy",       o_busy,       e_busy[cur]);
         chk1 ("mem_read",   o_mem_read,   e_mr[cur] && !i_rst);
         chk1 ("mem_write",  o_mem_write,  e_mw[cur] && !i_rst);
         chk32("mem_addr",   o_mem_addr,   e_addr[cur]);
         chk32("mem_wdata",  o_mem_wdata,  e_wd[cur]);
         chk1 ("resp_valid", o_resp_valid, e_rv[cur]);
         chk1 ("resp_err",   o_resp_err,   e_err[cur]);
         chk32("resp_rdata", o_resp_rdata, e_rd[cur]);
         if (o_resp_valid) resp_cnt++;
         if (e_cm[cur] && !i_rst) mmem[e_ci[cur]] = e_cw[cur];
         m_clear(cur);
         if (i_rst) begin
            for (int s = 0; s < 16; s++) m_clear(s);
         end else if (i_req_valid && exp_ready) begin
            m_accept(i_req_load, i_req_funct3, i_req_addr, i_req_wdata);
         end
         cur = (cur + 1) % 16;
      end
   end

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin
      #300000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      summary();
      $finish;
   end

   task automatic do_req(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
      int n;
      @(posedge clk); #1;
      i_req_valid  = 1'b1;
      i_req_load   = ld;
      i_req_funct3 = f3;
      i_req_addr   = a;
      i_req_wdata  = wd;
      n = 0;
      @(negedge clk);
      while (!o_req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!o_req_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got ready=0 expected ready=1");
      end
      @(posedge clk); #1;
      i_req_valid  = 1'b0;
      i_req_load   = 1'($urandom);
      i_req_funct3 = 3'($urandom);
      i_req_addr   = $urandom;
      i_req_wdata  = $urandom;
      lat = 0;
      rd  = 'x;
      er  = 1'bx;
      while (lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (o_resp_valid) begin
            rd = o_resp_rdata;
            er = o_resp_err;
            break;
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, r0, acc, cyc;
      int          acc_at [4];
      bit          take;
      bit          rl;
      logic [2:0]  rf;
      logic [2:0]  legal_f3 [5];

      legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      i_rst = 1'b1; i_req_valid = 1'b0; i_req_load = 1'b0;
      i_req_funct3 = 3'd0; i_req_addr = 32'd0; i_req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1 i_rst = 1'b0;
      @(negedge clk);
      chk1("ready_after_reset", o_req_ready, 1'b1);
      chk1("busy_after_reset",  o_busy,      1'b0);

      chk32("model_lb",  m_load(32'h80FF7F01, 3'b000, 3), 32'hFFFFFF80);
      chk32("model_sh",  m_merge(32'h1122AA44, 32'h0000BEEF, 3'b001, 2), 32'hBEEFAA44);

      // SW then LW
      do_req(1'b0, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk32("sw_lat", 32'(lat), 32'd2);
      chk1 ("sw_err", er, 1'b0);
      chk32("sw_mem", bmem[4], 32'hDEADBEEF);
      do_req(1'b1, 3'b010, 32'h10, 32'h0, rd, er, lat);
      chk32("lw_lat",   32'(lat), 32'd2);
      chk32("lw_rdata", rd, 32'hDEADBEEF);

      // sub-word loads
      do_req(1'b0, 3'b010, 32'h10, 32'h80FF7F01, rd, er, lat);
      do_req(1'b1, 3'b000, 32'h13, 32'h0, rd, er, lat);
      chk32("lb_13",  rd, 32'hFFFFFF80);
      do_req(1'b1, 3'b100, 32'h13, 32'h0, rd, er, lat);
      chk32("lbu_13", rd, 32'h00000080);
      do_req(1'b1, 3'b001, 32'h12, 32'h0, rd, er, lat);
      chk32("lh_12",  rd, 32'hFFFF80FF);
      do_req(1'b1, 3'b101, 32'h10, 32'h0, rd, er, lat);
      chk32("lhu_10", rd, 32'h00007F01);

      // read-modify-write stores
      do_req(1'b0, 3'b010, 32'h20, 32'h11223344, rd, er, lat);
      do_req(1'b0, 3'b000, 32'h21, 32'h000000AA, rd, er, lat);
      chk32("sb_lat", 32'(lat), 32'd3);
      chk32("sb_mem", bmem[8], 32'h1122AA44);
      do_req(1'b0, 3'b001, 32'h22, 32'h0000BEEF, rd, er, lat);
      chk32("sh_lat", 32'(lat), 32'd3);
      chk32("sh_mem", bmem[8], 32'hBEEFAA44);

      // errors
      do_req(1'b1, 3'b010, 32'h06, 32'h0, rd, er, lat);
      chk32("mis_lat",   32'(lat), 32'd1);
      chk1 ("mis_err",   er, 1'b1);
      chk32("mis_rdata", rd, 32'h0);
      do_req(1'b1, 3'b011, 32'h10, 32'h0, rd, er, lat);
      chk32("ill_lat", 32'(lat), 32'd1);
      chk1 ("ill_err", er, 1'b1);

      // reset during RMW_WR of SB 0x20
      @(posedge clk); #1;
      i_req_valid = 1'b1; i_req_load = 1'b0; i_req_funct3 = 3'b000;
      i_req_addr = 32'h20; i_req_wdata = 32'h55;
      @(negedge clk);
      chk1("abort_accept", o_req_ready, 1'b1);
      @(posedge clk); #1 i_req_valid = 1'b0;
      @(posedge clk); #1 i_rst = 1'b1;
      @(posedge clk); #1 i_rst = 1'b0;
      r0 = resp_cnt;
      @(negedge clk);
      chk1("ready_after_abort", o_req_ready, 1'b1);
      repeat (4) @(negedge clk);
      @(posedge clk);
      chk32("abort_no_resp", 32'(resp_cnt - r0), 32'd0);
      chk32("abort_mem", bmem[8], 32'hBEEFAA44);

      // back-to-back SW with valid held high
      #1;
      i_req_valid = 1'b1; i_req_load = 1'b0; i_req_funct3 = 3'b010;
      i_req_addr = 32'h30; i_req_wdata = 32'hC0DE0000;
      r0 = resp_cnt; acc = 0; cyc = 0;
      while (acc < 4 && cyc < 40) begin
         @(negedge clk);
         take = o_req_ready;
         @(posedge clk);
         cyc++;
         if (take) begin
            acc_at[acc] = cyc;
            acc++;
            #1;
            if (acc < 4) begin
               i_req_addr  = 32'h30 + 32'(4 * acc);
               i_req_wdata = 32'hC0DE0000 + 32'(acc);
            end else begin
               i_req_valid = 1'b0;
            end
         end
      end
      chk32("b2b_accepts", 32'(acc), 32'd4);
      for (int i = 1; i < 4; i++) chk32("b2b_interval", 32'(acc_at[i] - acc_at[i-1]), 32'd3);
      repeat (4) @(negedge clk);
      @(posedge clk);
      chk32("b2b_resps", 32'(resp_cnt - r0), 32'd4);
      for (int i = 0; i < 4; i++) chk32("b2b_mem", bmem[12 + i], 32'hC0DE0000 + 32'(i));

      // randomized traffic
      for (int i = 0; i < 250; i++) begin
         rl = 1'($urandom);
         if ($urandom_range(0, 3) == 0) rf = 3'($urandom);
         else rf = legal_f3[$urandom_range(0, 4)];
         do_req(rl, rf, 32'($urandom_range(0, 255)), $urandom, rd, er, lat);
         if (lat >= 10) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: got no response expected one within 10 cycles");
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (5) @(negedge clk);
      for (int i = 0; i < 64; i++) chk32("final_mem", bmem[i], mmem[i]);
      summary();
      $finish;
   end

endmodule
